pool_window_packer: RTL
=======================

POOL_WINDOW_PACKER -- requirements
Module: pool_window_packer

Interface
REQ-001 SHALL have ports: clk_cal  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have ports: rst_cal_n  in  1  reset; synchronous, active-low.
REQ-003 SHALL have ports: Start  in  1  one-cycle pulse; begins frame, samples P and Relu_en.
REQ-004 SHALL have ports: P  in  3  pooling window size; legal values 2, 4, 5, 7.
REQ-005 SHALL have ports: Relu_en  in  1  1 = clamp negative input bytes to 0 before packing.
REQ-006 SHALL have ports: Conv_OData  in  8  signed input sample.
REQ-007 SHALL have ports: Conv_OData_vld  in  1  qualifies Conv_OData; no backpressure.
REQ-008 SHALL have ports: Frame_last  in  1  marks the last sample of the frame; valid only with Conv_OData_vld.
REQ-009 SHALL have ports: Pool_IData  out  56  packed window; lane k (sample k of window, k=0..6) at bits [8k+7:8k].
REQ-010 SHALL have ports: Pool_IData_vld  out  1  one-cycle pulse per packed window.
REQ-011 SHALL have ports: Win_cnt  out  16  windows emitted in current frame.
REQ-012 SHALL have ports: Done  out  1  one-cycle pulse at frame end.
REQ-013 SHALL have ports: Err  out  1  sticky illegal-P flag; cleared by next Start or reset.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, FLUSH; reset state IDLE.
REQ-015 IDLE: Start with legal P -> RUN, lane index cleared, Win_cnt cleared, Err cleared; Start with illegal P -> stay IDLE, Err=1.
REQ-016 Inputs with Conv_OData_vld in IDLE or FLUSH SHALL be ignored.
REQ-017 RUN: each valid sample SHALL be written to lane[idx] (after ReLU clamp if Relu_en latched), idx increments.
REQ-018 When the sample filling lane P-1 is accepted, Pool_IData and Pool_IData_vld=1 SHALL be registered on the next edge (latency 1 cycle); idx wraps to 0; Win_cnt increments on the same edge.
REQ-019 Lanes k >= P SHALL always hold PAD 8'h80 in every emitted window.
REQ-020 Frame_last on a window-completing sample: emit normally, then -> FLUSH.
REQ-021 Frame_last with partial window (idx+1 < P): emit next cycle with unfilled lanes = 8'h80, Win_cnt increments, -> FLUSH.
REQ-022 FLUSH SHALL last one cycle, assert Done=1 during it, then -> IDLE; Done asserts the cycle after the final Pool_IData_vld.
REQ-023 Start in RUN SHALL abort the frame: partial window discarded, no emit, no Done, restart per REQ-015.
REQ-024 Start in FLUSH SHALL be ignored.
REQ-025 Pool_IData SHALL hold last emitted value between pulses; Pool_IData_vld never high two consecutive cycles unless windows complete on consecutive samples (P=2 back-to-back: max rate 1 per 2 cycles).
REQ-026 Win_cnt SHALL saturate at 16'hFFFF.
REQ-027 ReLU: byte with bit7=1 -> 8'h00 when Relu_en; else unchanged; PAD lanes never clamped.

Reset
REQ-028 On rst_cal_n=0 at a clock edge: state IDLE, idx 0, Pool_IData 56'h0, Pool_IData_vld 0, Win_cnt 0, Done 0, Err 0, latched P/Relu_en 0; applies mid-frame, partial window discarded.

Structure
REQ-029 Shared package pool_pkg SHALL hold BYTE_W=8, WIN_MAX=7, PACK_W=56, PAD_BYTE=8'h80, legal P constants, FSM state encoding.
REQ-030 One sub-module relu8 (8-bit signed clamp, combinational) SHALL be instantiated on the input path; all else in one module.

Verification
REQ-031 P=4, Relu_en=0, samples 1,2,3,4 -> one pulse, Pool_IData=56'h80_80_80_04_03_02_01, Win_cnt=1.
REQ-032 P=7, Relu_en=1, samples -5,6,-1,7,2,3,-8 with Frame_last on 7th -> 56'h00_03_02_07_00_06_00, Done next cycle, Win_cnt=1.
REQ-033 P=5, 7 samples 10..16, Frame_last on 16 -> windows 56'h80_80_0E_0D_0C_0B_0A then 56'h80_80_80_80_80_10_0F, Win_cnt=2, Done after second.
REQ-034 Start with P=3 -> Err=1, no output; Start with P=2 -> Err cleared, operation normal.
REQ-035 P=4, 2 samples, then Start -> no emit, no Done, idx restarted; next 4 samples produce a single correct window.
REQ-036 rst_cal_n low for one cycle mid-window -> all outputs at reset values next cycle; subsequent samples ignored until Start.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared constants, FSM encoding and the legal-window-size check
// used by the pooling window packer.
package pool_pkg;

    localparam int BYTE_W = 8;
    localparam int WIN_MAX = 7;
    localparam int PACK_W = BYTE_W * WIN_MAX;
    localparam logic [BYTE_W-1:0] PAD_BYTE = 8'h80;

    localparam logic [2:0] P_WIN_2 = 3'd2;
    localparam logic [2:0] P_WIN_4 = 3'd4;
    localparam logic [2:0] P_WIN_5 = 3'd5;
    localparam logic [2:0] P_WIN_7 = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    function automatic logic is_legal_p(input logic [2:0] p);
        return (p == P_WIN_2) || (p == P_WIN_4) || (p == P_WIN_5) || (p == P_WIN_7);
    endfunction

endpackage

// File: rtl/pool_window_packer_if.sv
// Conv-side sample stream in, packed pooling windows and frame status out.
interface pool_window_packer_if;

    logic                        Start;
    logic [2:0]                  P;
    logic                        Relu_en;
    logic [7:0]                  Conv_OData;
    logic                        Conv_OData_vld;
    logic                        Frame_last;
    logic [pool_pkg::PACK_W-1:0] Pool_IData;
    logic                        Pool_IData_vld;
    logic [15:0]                 Win_cnt;
    logic                        Done;
    logic                        Err;

    modport master (
        output Start, P, Relu_en, Conv_OData, Conv_OData_vld, Frame_last,
        input  Pool_IData, Pool_IData_vld, Win_cnt, Done, Err
    );

    modport slave (
        input  Start, P, Relu_en, Conv_OData, Conv_OData_vld, Frame_last,
        output Pool_IData, Pool_IData_vld, Win_cnt, Done, Err
    );

endinterface

// File: rtl/relu8.sv
// Combinational 8-bit signed clamp: negative bytes become zero when enabled.
module relu8
    import pool_pkg::*;
(
    input  logic              en_i,
    input  logic [BYTE_W-1:0] din_i,
    output logic [BYTE_W-1:0] dout_o
);

    assign dout_o = (en_i && din_i[BYTE_W-1]) ? '0 : din_i;

endmodule

// File: rtl/pool_window_packer.sv
// Packs signed conv samples into P-wide pooling windows (unused lanes padded),
// with end-of-frame flush, abort on restart and a sticky illegal-P error.
module pool_window_packer
    import pool_pkg::*;
(
    input  logic                clk_cal,
    input  logic                rst_cal_n,
    pool_window_packer_if.slave bus
);

    state_e            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [2:0]        p_q, p_d;
    logic              relu_en_q, relu_en_d;
    logic [PACK_W-1:0] data_q, data_d;
    logic              vld_q, vld_d;
    logic [15:0]       win_cnt_q, win_cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [BYTE_W-1:0] lane_q [WIN_MAX];
    logic [BYTE_W-1:0] sample_c;
    logic [PACK_W-1:0] packed_c;
    logic              lane_we;
    logic              start_hit;
    logic              sample_ok;
    logic              win_full;

    relu8 u_relu (
        .en_i   (relu_en_q),
        .din_i  (bus.Conv_OData),
        .dout_o (sample_c)
    );

    // The completing sample goes straight into its lane; lanes beyond it are PAD,
    // which covers both k >= P and the unfilled tail of a flushed partial window.
    generate
        for (genvar gi = 0; gi < WIN_MAX; gi++) begin : g_lane
            assign packed_c[gi*BYTE_W +: BYTE_W] =
                (3'(gi) < idx_q)  ? lane_q[gi] :
                (3'(gi) == idx_q) ? sample_c   : PAD_BYTE;
        end
    endgenerate

    assign start_hit = bus.Start && (state_q != FLUSH);
    assign sample_ok = (state_q == RUN) && bus.Conv_OData_vld;
    assign win_full  = (idx_q == (p_q - 3'd1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        p_d       = p_q;
        relu_en_d = relu_en_q;
        data_d    = data_q;
        vld_d     = 1'b0;
        win_cnt_d = win_cnt_q;
        done_d    = 1'b0;
        err_d     = err_q;
        lane_we   = 1'b0;

        if (start_hit) begin
            if (is_legal_p(bus.P)) begin
                state_d   = RUN;
                idx_d     = '0;
                win_cnt_d = '0;
                err_d     = 1'b0;
                p_d       = bus.P;
                relu_en_d = bus.Relu_en;
            end else begin
                state_d = IDLE;
                err_d   = 1'b1;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (sample_ok) begin
                        if (win_full || bus.Frame_last) begin
                            data_d = packed_c;
                            vld_d  = 1'b1;
                            idx_d  = '0;
                            if (win_cnt_q != 16'hFFFF) begin
                                win_cnt_d = win_cnt_q + 16'd1;
                            end
                            if (bus.Frame_last) begin
                                state_d = FLUSH;
                            end
                        end else begin
                            lane_we = 1'b1;
                            idx_d   = idx_q + 3'd1;
                        end
                    end
                end
                // Done is registered here so it lands one cycle after the final window.
                FLUSH: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_cal) begin
        if (!rst_cal_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            p_q       <= '0;
            relu_en_q <= 1'b0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            win_cnt_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            p_q       <= p_d;
            relu_en_q <= relu_en_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            win_cnt_q <= win_cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Lane storage needs no reset: idx restarts at 0, so stale bytes are never read.
    always_ff @(posedge clk_cal) begin
        if (lane_we) begin
            lane_q[idx_q] <= sample_c;
        end
    end

    assign bus.Pool_IData     = data_q;
    assign bus.Pool_IData_vld = vld_q;
    assign bus.Win_cnt        = win_cnt_q;
    assign bus.Done           = done_q;
    assign bus.Err            = err_q;

endmodule
